// File: rtl/gsim_resid.sv
// gsim_resid: reconstructs b = A*x for a banded (7-tap) Toeplitz operator
// with taps c(0)=20, c(1)=-13, c(2)=6, c(3)=-1 applied to a Q16.16 vector.
// A frame is loaded word by word (LOAD), then each row takes 8 cycles in
// CALC: 7 MAC cycles over j=i-3..i+3 and one output cycle.
// Optional feature: define GSIM_RESID_SAT_EN to saturate b_out to 16 bits;
// otherwise the rounded value wraps to its low 16 bits.
module gsim_resid #(
  parameter int N_ELEM = 16,
  parameter int FRAC   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_en,
  input  logic signed [31:0] x_in,
  output logic               b_valid,
  output logic        [15:0] b_out,
  output logic               busy
);

  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int TAP_W = IDX_W + 4;
  localparam int ACC_W = 40;
  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (FRAC - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CALC} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;      // load index in LOAD, row index in CALC
  logic [2:0]               phase_q, phase_d;  // 0..6 MAC taps, 7 output cycle
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     b_valid_q, b_valid_d;
  logic [15:0]              b_out_q, b_out_d;
  logic                     busy_q, busy_d;

  logic signed [31:0]       x_mem [N_ELEM];
  logic                     wr_en;

  logic signed [TAP_W-1:0]  tap_s;
  logic                     tap_ok;
  logic [IDX_W-1:0]         tap_idx;
  logic signed [31:0]       x_tap;
  logic signed [5:0]        coef;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic [15:0]              narrow;

  // Column index j = i + phase - 3 for the current tap, with range check.
  always_comb begin
    tap_s   = $signed({4'b0000, idx_q})
            + $signed({{(TAP_W-3){1'b0}}, phase_q})
            - $signed(TAP_W'(3));
    tap_ok  = !tap_s[TAP_W-1] && (tap_s < TAP_W'(N_ELEM));
    tap_idx = tap_s[IDX_W-1:0];
    x_tap   = tap_ok ? x_mem[tap_idx] : '0;
  end

  // Tap coefficient depends only on |i-j| = |phase-3|.
  always_comb begin
    unique case (phase_q)
      3'd0, 3'd6: coef = -6'sd1;
      3'd1, 3'd5: coef = 6'sd6;
      3'd2, 3'd4: coef = -6'sd13;
      3'd3:       coef = 6'sd20;
      default:    coef = 6'sd0;
    endcase
  end

  // Multiply-accumulate and round-half-up (floor after adding half an LSB).
  always_comb begin
    prod    = $signed({{8{x_tap[31]}}, x_tap}) * $signed({{(ACC_W-6){coef[5]}}, coef});
    acc_sum = acc_q + prod;
    acc_rnd = acc_sum + RND_BIAS;
  end

`ifdef GSIM_RESID_SAT_EN
  logic signed [ACC_W-1:0] rounded;

  // Saturate the rounded result into the signed 16-bit range.
  always_comb begin
    rounded = acc_rnd >>> FRAC;
    if (rounded > ACC_W'(32767))       narrow = 16'h7FFF;
    else if (rounded < ACC_W'(-32768)) narrow = 16'h8000;
    else                               narrow = rounded[15:0];
  end
`else
  // Keep the low 16 bits of the rounded result (two's-complement wrap).
  assign narrow = 16'(acc_rnd >>> FRAC);
`endif

  // Next-state and datapath control for the IDLE/LOAD/CALC sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    acc_d     = acc_q;
    b_valid_d = 1'b0;
    b_out_d   = b_out_q;
    wr_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_en) begin
          wr_en = 1'b1;
          if (N_ELEM == 1) begin
            state_d = CALC;
            phase_d = '0;
            acc_d   = '0;
          end else begin
            state_d = LOAD;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      LOAD: begin
        if (in_en) begin
          wr_en = 1'b1;
          if (idx_q == IDX_W'(N_ELEM - 1)) begin
            state_d = CALC;
            idx_d   = '0;
            phase_d = '0;
            acc_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      CALC: begin
        if (phase_q == 3'd7) begin
          phase_d = '0;
          if (idx_q == IDX_W'(N_ELEM - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          phase_d = phase_q + 3'd1;
          acc_d   = acc_sum;
          if (phase_q == 3'd6) begin
            // Last tap: register the result so b_valid shows in the output cycle.
            b_valid_d = 1'b1;
            b_out_d   = narrow;
            acc_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      phase_q   <= '0;
      acc_q     <= '0;
      b_valid_q <= 1'b0;
      b_out_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      b_valid_q <= b_valid_d;
      b_out_q   <= b_out_d;
      busy_q    <= busy_d;
    end
  end

  // Solution vector storage, written during IDLE/LOAD at the load index.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; every frame overwrites all entries before use.
    if (wr_en) x_mem[idx_q] <= x_in;
  end

  assign b_valid = b_valid_q;
  assign b_out   = b_out_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_gsim_resid.sv
// Self-checking bench for gsim_resid: directed frames with known results,
// randomized frames against a behavioural model, gaps, held in_en, and
// reset in the middle of CALC.
module tb_gsim_resid;

  localparam int N    = 16;
  localparam int FRAC = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic [31:0] x_in;
  logic        b_valid;
  logic [15:0] b_out;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] frame_x [N];
  logic [15:0] exp_b   [N];
  logic [15:0] last_b;

  gsim_resid #(.N_ELEM(N), .FRAC(FRAC)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_en   (in_en),
    .x_in    (x_in),
    .b_valid (b_valid),
    .b_out   (b_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // b[i] = sum c(|i-j|) * x[j], rounded half up, then narrowed.
  function automatic logic [15:0] ref_b(input int i);
    int     c [4] = '{20, -13, 6, -1};
    longint acc = 0;
    longint r;
    for (int j = 0; j < N; j++) begin
      int d = (i > j) ? i - j : j - i;
      if (d <= 3) acc += longint'(c[d]) * longint'($signed(frame_x[j]));
    end
    r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
`ifdef GSIM_RESID_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic fill_exp_from_model();
    for (int i = 0; i < N; i++) exp_b[i] = ref_b(i);
  endtask

  // Called at #1 after a rising edge with the DUT idle. Loads frame_x,
  // then checks every CALC cycle. abort_c >= 0 pulls reset at that cycle.
  task automatic run_frame(input string name, input bit gaps, input bit hold, input int abort_c);
    int  k = 0;
    bit  vexp;
    while (k < N) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_en = 1'b0;
        x_in  = $urandom;
      end else begin
        in_en = 1'b1;
        x_in  = frame_x[k];
        k++;
      end
      @(posedge clk); #1;
      if (in_en && k == 1) check($sformatf("%s busy after first word", name), busy, 1'b1);
    end
    in_en = hold;
    x_in  = $urandom;
    for (int c = 0; c < 8 * N; c++) begin
      @(negedge clk);
      vexp = (c % 8 == 7);
      check($sformatf("%s b_valid cycle %0d", name, c), b_valid, vexp);
      check($sformatf("%s busy cycle %0d", name, c), busy, 1'b1);
      if (vexp) last_b = exp_b[c / 8];
      check($sformatf("%s b_out cycle %0d row %0d", name, c, c / 8), b_out, last_b);
      if (c == abort_c) begin
        in_en = 1'b0;
        reset = 1'b0;
        #1;
        check($sformatf("%s b_valid in reset", name), b_valid, 1'b0);
        check($sformatf("%s busy in reset", name), busy, 1'b0);
        check($sformatf("%s b_out in reset", name), b_out, 16'h0000);
        last_b = 16'h0000;
        return;
      end
      @(posedge clk); #1;
      if (hold) x_in = $urandom;
    end
    in_en = 1'b0;
    check($sformatf("%s busy after frame", name), busy, 1'b0);
    check($sformatf("%s b_valid after frame", name), b_valid, 1'b0);
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < N; i++) frame_x[i] = v;
  endtask

  task automatic set_ones_table();
    set_all(32'h00010000);
    exp_b = '{16'h000C, 16'hFFFF, 16'h0005, 16'h0004,
              16'h0004, 16'h0004, 16'h0004, 16'h0004,
              16'h0004, 16'h0004, 16'h0004, 16'h0004,
              16'h0004, 16'h0005, 16'hFFFF, 16'h000C};
  endtask

  initial begin
    reset  = 1'b0;
    in_en  = 1'b0;
    x_in   = '0;
    last_b = 16'h0000;
    #1;
    check("reset b_valid", b_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset b_out", b_out, 16'h0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("idle busy", busy, 1'b0);

    // All ones: edge rows see truncated bands.
    set_ones_table();
    run_frame("ones", 1'b0, 1'b0, -1);

    // Single unit impulse at x[5] (starts back-to-back with the previous frame).
    set_all(32'h0);
    frame_x[5] = 32'h00010000;
    for (int i = 0; i < N; i++) exp_b[i] = 16'h0000;
    exp_b[2] = 16'hFFFF; exp_b[3] = 16'h0006; exp_b[4] = 16'hFFF3; exp_b[5] = 16'h0014;
    exp_b[6] = 16'hFFF3; exp_b[7] = 16'h0006; exp_b[8] = 16'hFFFF;
    run_frame("impulse5", 1'b0, 1'b0, -1);

    // Half-unit at x[0]: exercises round-half-up on negative values.
    set_all(32'h0);
    frame_x[0] = 32'h00008000;
    for (int i = 0; i < N; i++) exp_b[i] = 16'h0000;
    exp_b[0] = 16'h000A; exp_b[1] = 16'hFFFA; exp_b[2] = 16'h0003; exp_b[3] = 16'h0000;
    run_frame("half0", 1'b0, 1'b0, -1);

    // Large values: saturate or wrap depending on build.
    set_all(32'h7FFF0000);
    fill_exp_from_model();
`ifdef GSIM_RESID_SAT_EN
    exp_b[0] = 16'h7FFF;
`else
    exp_b[0] = 16'hFFF4;
`endif
    run_frame("big", 1'b0, 1'b0, -1);

    // Random frames: gap-free, then identical data with gaps and in_en held through CALC.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++)
        frame_x[i] = (f < 2) ? $urandom : (32'($urandom_range(0, 32'h3FFFF)) - 32'h20000);
      fill_exp_from_model();
      run_frame($sformatf("rand%0d plain", f), 1'b0, 1'b0, -1);
      run_frame($sformatf("rand%0d gaps", f), 1'b1, 1'b1, -1);
    end

    // Reset during the row 4 output cycle, then a clean frame.
    set_ones_table();
    run_frame("abort", 1'b0, 1'b0, 8 * 4 + 7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check($sformatf("post-reset b_valid cycle %0d", c), b_valid, 1'b0);
      check($sformatf("post-reset busy cycle %0d", c), busy, 1'b0);
    end
    @(posedge clk); #1;
    set_ones_table();
    run_frame("after reset", 1'b1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
